// File: rtl/vt_cursor_ctl_if.sv
// Command handshake plus Wishbone master bus of the cursor controller.
// master = controller side; slave = command source / video-register block side.
interface vt_cursor_ctl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [5:0]  cmd_row;
    logic [6:0]  cmd_col;
    logic [15:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [1:0]  wb_sel_o;
    logic        wb_ack_i;

    modport master (
        input  cmd_valid, cmd_op, cmd_row, cmd_col, wb_ack_i,
        output cmd_ready, wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_row, cmd_col, wb_ack_i,
        input  cmd_ready, wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o
    );
endinterface

// File: rtl/vt_cursor_ctl.sv
// Text cursor controller: moves row/col per command and writes the cursor address to the video block.
// Busy 2 cycles + Wishbone ack wait per move; cmd_ready only in IDLE, so commands stall during the write.
module vt_cursor_ctl #(
    parameter logic [15:0] BASE = 16'h0000,
    parameter int          COLS = 80
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    vt_cursor_ctl_if.master bus,
    input  logic        mode38,
    input  logic [12:0] vbase,
    output logic [5:0]  row,
    output logic [6:0]  col,
    output logic        scroll_o
);
    localparam logic [3:0] OP_HOME  = 4'd1;
    localparam logic [3:0] OP_UP    = 4'd2;
    localparam logic [3:0] OP_DOWN  = 4'd3;
    localparam logic [3:0] OP_LEFT  = 4'd4;
    localparam logic [3:0] OP_RIGHT = 4'd5;
    localparam logic [3:0] OP_CR    = 4'd6;
    localparam logic [3:0] OP_LF    = 4'd7;
    localparam logic [3:0] OP_SET   = 4'd8;
    localparam logic [6:0] COL_MAX  = 7'(COLS - 1);

    typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  row_nxt, maxrow, row_clamp;
    logic [6:0]  col_nxt;
    logic [12:0] addr, addr_nxt;
    logic        scroll_nxt;
    logic        in_write;

    always_comb begin
        state_nxt  = state;
        row_nxt    = row;
        col_nxt    = col;
        addr_nxt   = addr;
        scroll_nxt = 1'b0;
        maxrow     = mode38 ? 6'd37 : 6'd23;
        // a row left beyond the screen by a 38->24 mode switch is pulled back first
        row_clamp  = (row > maxrow) ? maxrow : row;

        case (state)
            IDLE: begin
                if (bus.cmd_valid && bus.cmd_op >= OP_HOME && bus.cmd_op <= OP_SET) begin
                    state_nxt = CALC;
                    row_nxt   = row_clamp;
                    case (bus.cmd_op)
                        OP_HOME: begin
                            row_nxt = 6'd0;
                            col_nxt = 7'd0;
                        end
                        OP_UP:    row_nxt = (row_clamp == 6'd0) ? 6'd0 : row_clamp - 6'd1;
                        OP_DOWN:  row_nxt = (row_clamp < maxrow) ? row_clamp + 6'd1 : row_clamp;
                        OP_LEFT:  col_nxt = (col == 7'd0) ? 7'd0 : col - 7'd1;
                        OP_RIGHT: col_nxt = (col < COL_MAX) ? col + 7'd1 : COL_MAX;
                        OP_CR:    col_nxt = 7'd0;
                        OP_LF: begin
                            if (row_clamp < maxrow) row_nxt = row_clamp + 6'd1;
                            else                    scroll_nxt = 1'b1;
                        end
                        OP_SET: begin
                            row_nxt = (bus.cmd_row > maxrow)  ? maxrow  : bus.cmd_row;
                            col_nxt = (bus.cmd_col > COL_MAX) ? COL_MAX : bus.cmd_col;
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                addr_nxt  = vbase + 13'(row) * 13'(COLS) + 13'(col);
                state_nxt = WRITE;
            end
            WRITE: begin
                if (bus.wb_ack_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            row      <= 6'd0;
            col      <= 7'd0;
            addr     <= 13'd0;
            scroll_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            row      <= row_nxt;
            col      <= col_nxt;
            addr     <= addr_nxt;
            scroll_o <= scroll_nxt;
        end
    end

    assign in_write      = (state == WRITE);
    assign bus.cmd_ready = (state == IDLE);
    assign bus.wb_cyc_o  = in_write;
    assign bus.wb_stb_o  = in_write;
    assign bus.wb_we_o   = in_write;
    assign bus.wb_sel_o  = in_write ? 2'b11 : 2'b00;
    assign bus.wb_adr_o  = in_write ? BASE : 16'h0000;
    assign bus.wb_dat_o  = in_write ? {3'b000, addr} : 16'h0000;
endmodule

// File: doc/vt_cursor_ctl.md
VT_CURSOR_CTL -- requirements
Module: vt_cursor_ctl

Interface
REQ-001 SHALL have parameter: BASE, 16'h0000, byte address of the cursor register on the video-register bus.
REQ-002 SHALL have parameter: COLS, 80, characters per line.
REQ-003 SHALL have port: wb_clk_i  in  1  the only clock; all logic on the rising edge.
REQ-004 SHALL have port: wb_rst_i  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port: cmd_valid  in  1  command request.
REQ-006 SHALL have port: cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-007 SHALL have port: cmd_op  in  4  opcode: 0 NOP, 1 HOME, 2 UP, 3 DOWN, 4 LEFT, 5 RIGHT, 6 CR, 7 LF, 8 SET; 9-15 reserved.
REQ-008 SHALL have port: cmd_row  in  6  target row for SET.
REQ-009 SHALL have port: cmd_col  in  7  target column for SET.
REQ-010 SHALL have port: mode38  in  1  screen mode (control-register bit D1): 0 = 24 rows, 1 = 38 rows.
REQ-011 SHALL have port: vbase  in  13  video-memory address of the screen's top-left character.
REQ-012 SHALL have ports: wb_adr_o out 16, wb_dat_o out 16, wb_cyc_o out 1, wb_stb_o out 1, wb_we_o out 1, wb_sel_o out 2, wb_ack_i in 1; together these form the Wishbone master port.
REQ-013 SHALL have port: row  out  6  current cursor row.
REQ-014 SHALL have port: col  out  7  current cursor column.
REQ-015 SHALL have port: scroll_o  out  1  one-cycle pulse requesting a screen scroll.

Function
REQ-016 SHALL implement a state machine with three states: IDLE, CALC and WRITE.
REQ-017 SHALL assert cmd_ready only in IDLE.
REQ-018 SHALL, on an accepted opcode 1-8, move IDLE->CALC; on an accepted NOP or reserved opcode, stay in IDLE with no state change and no bus cycle.
REQ-019 SHALL define maxrow as 37 when mode38=1 and 23 otherwise, sampled in the acceptance cycle.
REQ-020 SHALL apply the following row/col updates in the cycle the command is accepted, so they are visible in CALC:
- HOME: row=0, col=0.
- UP: row-1, saturating at 0.
- DOWN: row+1, saturating at maxrow; no scroll.
- LEFT: col-1, saturating at 0.
- RIGHT: col+1, saturating at COLS-1.
- CR: col=0.
- LF: if row<maxrow then row+1; else row unchanged and scroll_o=1 for the single CALC cycle.
- SET: row=min(cmd_row,maxrow), col=min(cmd_col,COLS-1).
REQ-021 SHALL, for any opcode other than HOME and SET, first clamp a row above maxrow (left over from a mode change) to maxrow.
REQ-022 SHALL, in CALC, register addr = (vbase + row*COLS + col) mod 2^13 and go to WRITE.
REQ-023 SHALL, throughout WRITE, drive wb_cyc_o=wb_stb_o=wb_we_o=1, wb_sel_o=2'b11, wb_adr_o=BASE and wb_dat_o={3'b000,addr}, all held stable until wb_ack_i.
REQ-024 SHALL, on the cycle wb_ack_i=1 is sampled in WRITE, go to IDLE and deassert cyc/stb/we on the following cycle; wb_ack_i outside WRITE is ignored.
REQ-025 SHALL produce a minimum command-to-command spacing of 4 cycles when the slave acks one cycle after stb, which is the behaviour of the video-register block.
REQ-026 SHALL keep row and col unchanged while not in IDLE.
REQ-027 SHALL drive wb_dat_o, wb_adr_o and wb_sel_o to 0 outside WRITE.

Reset
REQ-028 SHALL, while wb_rst_i=1 at a clock edge, enter IDLE and set row=0, col=0, addr=0, scroll_o=0, wb_cyc_o=wb_stb_o=wb_we_o=0 and wb_sel_o=0; cmd_ready reads 1 once wb_rst_i is released.
REQ-029 SHALL, on reset during WRITE, drop cyc/stb at the next edge without waiting for ack, discarding the pending update.

Verification
REQ-030 SHALL cover: reset; SET row=5 col=10, vbase=0, mode38=0, ack at stb+1 -> one write, adr=BASE, dat=16'h019A (410), back in IDLE 4 cycles after acceptance.
REQ-031 SHALL cover: row=23, mode38=0; LF -> scroll_o high exactly 1 cycle, row stays 23; DOWN -> no scroll, row 23; same with mode38=1 -> row 24, no scroll.
REQ-032 SHALL cover: col=79; RIGHT -> col 79; col=0 LEFT -> 0; row=0 UP -> 0; each still issues one write with an unchanged address.
REQ-033 SHALL cover: SET row=63 col=127, mode38=1 -> row 37, col 79, dat=3039; vbase=13'h1F00 with row 37 col 79 -> dat=(7936+3039) mod 8192=2783.
REQ-034 SHALL cover: ack delayed 5 cycles with cmd_valid held high -> adr/dat stable, cmd_ready=0 throughout, next command accepted only after return to IDLE; opcode 12 -> accepted, no cyc.
REQ-035 SHALL cover: reset asserted mid-WRITE -> cyc/stb low at next edge, row=col=0; mode38 switched 1->0 with row=30, then CR -> row 23, col 0.
